fifo_frame_builder: RTL
=======================

Name: fifo_frame_builder

Overview:
- Downstream consumer of the channel sample FIFO, which is first-word-fall-through: DOUT shows the head word; RE pops it.
- Drains FIFO words and wraps them into fixed-length frames: one header word, FRAME_LEN payload words, one footer word.
- Presents frames on a valid/ready stream toward the readout merger.
- A payload timeout closes a frame early when the FIFO runs dry, and marks the frame truncated.

Parameters:
- DATA_WIDTH, 16: FIFO and stream word width; must be >= 16.
- FRAME_LEN, 8: payload words per frame; must be >= 1.
- TIMEOUT, 64: consecutive empty cycles in PAYLOAD before early close; 0 disables the timeout.
- CHANNEL_ID, 0: 8-bit channel tag placed in the header.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-low reset
- EN  in  1  frame start enable
- FIFO_DOUT  in  DATA_WIDTH  FIFO head word
- FIFO_EMPTY  in  1  FIFO empty flag
- FIFO_RE  out  1  FIFO pop strobe, combinational
- M_TDATA  out  DATA_WIDTH  stream data, registered
- M_TVALID  out  1  stream valid, registered
- M_TLAST  out  1  high on the footer word
- M_TREADY  in  1  downstream ready
- BUSY  out  1  high when state is not IDLE

Behaviour:
- Reset: clock CLK; reset RESET is synchronous and active-low. While RESET=0:
  - state=IDLE
  - M_TVALID=0, M_TDATA=0, M_TLAST=0, FIFO_RE=0, BUSY=0
  - seq=0, payload counter=0, timeout counter=0
- Reset mid-frame aborts the frame immediately. No footer is sent. The partial frame is lost downstream.
- Output register: load_en = !M_TVALID || M_TREADY. A word transfers when M_TVALID && M_TREADY.
- M_TVALID, M_TDATA and M_TLAST hold stable while M_TVALID=1 and M_TREADY=0.
- When load_en=1 and nothing is loaded, M_TVALID goes 0.
- Word formats (bits above 15 are zero):
  - Header: [15:12]=4'hA, [11:8]=0, [7:0]=CHANNEL_ID.
  - Payload: FIFO_DOUT unchanged.
  - Footer: [15:12]=4'h5, [11]=truncated, [10:8]=0, [7:0]=seq.
- IDLE:
  - If EN && !FIFO_EMPTY && load_en: load header, M_TLAST=0, go to PAYLOAD, clear payload and timeout counters.
  - Header is valid 1 cycle after the condition is seen. The header does not pop the FIFO.
- PAYLOAD:
  - FIFO_RE = !FIFO_EMPTY && load_en (same cycle). When FIFO_RE=1, load FIFO_DOUT, increment the payload counter, clear the timeout counter.
  - When the FRAME_LEN-th word is loaded: go to FOOTER, truncated=0.
  - If FIFO_EMPTY: timeout counter increments every cycle, including stall cycles. When it reaches TIMEOUT (TIMEOUT>0): go to FOOTER, truncated=1.
  - The FIFO is still non-empty after the header, so every frame carries at least 1 payload word.
  - If FIFO_EMPTY=0 but load_en=0 (backpressure), the timeout counter holds.
- FOOTER:
  - When load_en: load footer with M_TLAST=1, then seq <= seq+1 (8-bit, 255 wraps to 0), go to IDLE.
- FIFO_RE is never asserted outside PAYLOAD and never while FIFO_EMPTY=1.
- EN is sampled only in IDLE. Deasserting EN mid-frame lets the current frame complete normally.
- Throughput: with no stalls, a frame takes FRAME_LEN+2 consecutive valid cycles. Back-to-back frames need 1 IDLE cycle between footer and next header.
- FRAME_LEN=1: the frame is header, 1 payload word, footer.

Test Plan:
- FRAME_LEN=4, CHANNEL_ID=3; FIFO holds 0x0101..0x0104; EN=1; TREADY=1 -> stream is 0xA003, 0x0101, 0x0102, 0x0103, 0x0104, 0x5000 with TLAST only on 0x5000; exactly 4 FIFO_RE pulses; BUSY falls after the footer.
- Same setup but only 2 words available, TIMEOUT=8 -> header, 0x0101, 0x0102, then footer 0x5800 exactly 8 empty cycles after the last pop.
- Backpressure: TREADY toggles 1,0,0,1,... during a frame -> no word is dropped or duplicated; TDATA is stable while stalled; FIFO_RE fires only on load cycles; a stall with the FIFO non-empty does not cause a timeout.
- 257 full frames -> footer seq goes 0x00..0xFF, then 0x00 (footer 0x5000 again).
- Assert RESET=0 during the 3rd payload word -> next cycle TVALID=0, BUSY=0, seq=0; the next frame starts with a header.
- EN=0 with FIFO non-empty -> no output, no FIFO_RE. EN deasserted after the header -> the frame still completes with its footer.

Source files
------------

// File: rtl/fifo_frame_builder.sv
// Frame builder: drains a first-word-fall-through FIFO into header / payload / footer
// frames and presents them on a registered valid/ready stream.
module fifo_frame_builder #(
    parameter int          DATA_WIDTH = 16,
    parameter int          FRAME_LEN  = 8,
    parameter int          TIMEOUT    = 64,
    parameter logic [7:0]  CHANNEL_ID = 8'd0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  EN,
    input  logic [DATA_WIDTH-1:0] FIFO_DOUT,
    input  logic                  FIFO_EMPTY,
    output logic                  FIFO_RE,
    output logic [DATA_WIDTH-1:0] M_TDATA,
    output logic                  M_TVALID,
    output logic                  M_TLAST,
    input  logic                  M_TREADY,
    output logic                  BUSY
);

    localparam int PCNT_W = $clog2(FRAME_LEN + 1);
    localparam int TCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_FOOTER  = 2'd2
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] header_word();
        logic [DATA_WIDTH-1:0] w;
        w        = '0;
        w[15:12] = 4'hA;
        w[7:0]   = CHANNEL_ID;
        return w;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] footer_word(input logic trunc, input logic [7:0] seq);
        logic [DATA_WIDTH-1:0] w;
        w        = '0;
        w[15:12] = 4'h5;
        w[11]    = trunc;
        w[7:0]   = seq;
        return w;
    endfunction

    state_t                state_r, state_s;
    logic [7:0]            seq_r, seq_s;
    logic [PCNT_W-1:0]     pcnt_r, pcnt_s;
    logic [TCNT_W-1:0]     tcnt_r, tcnt_s;
    logic                  trunc_r, trunc_s;
    logic [DATA_WIDTH-1:0] tdata_r, tdata_s;
    logic                  tvalid_r, tvalid_s;
    logic                  tlast_r, tlast_s;
    logic                  load_en_s;
    logic                  re_s;

    // Next-state, output-register load and FIFO pop decision.
    always_comb begin
        state_s   = state_r;
        seq_s     = seq_r;
        pcnt_s    = pcnt_r;
        tcnt_s    = tcnt_r;
        trunc_s   = trunc_r;
        tdata_s   = tdata_r;
        tvalid_s  = tvalid_r;
        tlast_s   = tlast_r;
        re_s      = 1'b0;
        load_en_s = !tvalid_r || M_TREADY;

        // An open output slot with nothing new to put in it drops valid.
        if (load_en_s) begin
            tvalid_s = 1'b0;
            tlast_s  = 1'b0;
        end else begin
            tvalid_s = tvalid_r;
            tlast_s  = tlast_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (EN && !FIFO_EMPTY && load_en_s) begin
                    tdata_s  = header_word();
                    tvalid_s = 1'b1;
                    tlast_s  = 1'b0;
                    pcnt_s   = '0;
                    tcnt_s   = '0;
                    state_s  = ST_PAYLOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (!FIFO_EMPTY && load_en_s) begin
                    re_s     = 1'b1;
                    tdata_s  = FIFO_DOUT;
                    tvalid_s = 1'b1;
                    tlast_s  = 1'b0;
                    pcnt_s   = pcnt_r + {{(PCNT_W-1){1'b0}}, 1'b1};
                    tcnt_s   = '0;
                    if (pcnt_r == PCNT_W'(FRAME_LEN - 1)) begin
                        trunc_s = 1'b0;
                        state_s = ST_FOOTER;
                    end else begin
                        state_s = ST_PAYLOAD;
                    end
                end else if (FIFO_EMPTY) begin
                    // Dry cycles count even while the output is stalled.
                    if (TIMEOUT > 0) begin
                        tcnt_s = tcnt_r + {{(TCNT_W-1){1'b0}}, 1'b1};
                        if (tcnt_r == TCNT_W'(TIMEOUT - 1)) begin
                            trunc_s = 1'b1;
                            state_s = ST_FOOTER;
                        end else begin
                            state_s = ST_PAYLOAD;
                        end
                    end else begin
                        tcnt_s = tcnt_r;
                    end
                end else begin
                    tcnt_s = tcnt_r;
                end
            end
            ST_FOOTER: begin
                if (load_en_s) begin
                    tdata_s  = footer_word(trunc_r, seq_r);
                    tvalid_s = 1'b1;
                    tlast_s  = 1'b1;
                    seq_s    = seq_r + 8'd1;
                    state_s  = ST_IDLE;
                end else begin
                    state_s = ST_FOOTER;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                tvalid_s = 1'b0;
                tlast_s  = 1'b0;
            end
        endcase
    end

    // State, counters and stream output register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r  <= ST_IDLE;
            seq_r    <= 8'd0;
            pcnt_r   <= '0;
            tcnt_r   <= '0;
            trunc_r  <= 1'b0;
            tdata_r  <= '0;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            seq_r    <= seq_s;
            pcnt_r   <= pcnt_s;
            tcnt_r   <= tcnt_s;
            trunc_r  <= trunc_s;
            tdata_r  <= tdata_s;
            tvalid_r <= tvalid_s;
            tlast_r  <= tlast_s;
        end
    end

    // The pop strobe is masked during reset so an aborted frame never consumes a word.
    assign FIFO_RE  = re_s && RESET;
    assign BUSY     = RESET && (state_r != ST_IDLE);
    assign M_TDATA  = tdata_r;
    assign M_TVALID = tvalid_r;
    assign M_TLAST  = tlast_r;

endmodule
